// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/datapath bundle for multicycle_control
// master = controller side, slave = datapath side.
interface multicycle_control_if #(
  parameter int OP_W    = 7,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 32
);
  logic [OP_W-1:0]    Op_i;
  logic               Zero_i;
  logic               MemReady_i;
  logic [ALUOP_W-1:0] ALUOp_o;
  logic               ALUSrc_o;
  logic               RegWrite_o;
  logic               MemRead_o;
  logic               MemWrite_o;
  logic               MemtoReg_o;
  logic               IRWrite_o;
  logic               PCWrite_o;
  logic               PCSrc_o;
  logic               Illegal_o;
  logic [2:0]         State_o;
  logic [CNT_W-1:0]   CycleCnt_o;
  logic [CNT_W-1:0]   InstRet_o;

  modport master (
    input  Op_i, Zero_i, MemReady_i,
    output ALUOp_o, ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o,
           IRWrite_o, PCWrite_o, PCSrc_o, Illegal_o, State_o, CycleCnt_o, InstRet_o
  );

  modport slave (
    output Op_i, Zero_i, MemReady_i,
    input  ALUOp_o, ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o,
           IRWrite_o, PCWrite_o, PCSrc_o, Illegal_o, State_o, CycleCnt_o, InstRet_o
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RISC-V control FSM with memory-ready stalls
// Optional performance counters enabled by defining CTRL_PERF_CNT_EN.
module multicycle_control #(
  parameter int OP_W    = 7,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_MADDR  = 3'd4,
    S_MEM    = 3'd5,
    S_BRANCH = 3'd6
  } state_t;

  localparam logic [OP_W-1:0] OP_R   = OP_W'(7'b0110011);
  localparam logic [OP_W-1:0] OP_I   = OP_W'(7'b0010011);
  localparam logic [OP_W-1:0] OP_LD  = OP_W'(7'b0000011);
  localparam logic [OP_W-1:0] OP_ST  = OP_W'(7'b0100011);
  localparam logic [OP_W-1:0] OP_BEQ = OP_W'(7'b1100011);

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);

  state_t          r_state;
  logic [OP_W-1:0] r_op;

  logic               w_is_r;
  logic               w_is_ld;
  logic               w_is_st;
  logic               w_dec_legal;
  logic [ALUOP_W-1:0] w_aluop;
  logic               w_alusrc;
  logic               w_regwrite;
  logic               w_memread;
  logic               w_memwrite;
  logic               w_memtoreg;
  logic               w_irwrite;
  logic               w_pcwrite;
  logic               w_pcsrc;
  logic               w_illegal;

  // Full-width compares, so any nonzero upper opcode bit makes the opcode illegal.
  assign w_is_r      = (r_op == OP_R);
  assign w_is_ld     = (r_op == OP_LD);
  assign w_is_st     = (r_op == OP_ST);
  assign w_dec_legal = (bus.Op_i == OP_R) || (bus.Op_i == OP_I) || (bus.Op_i == OP_LD) ||
                       (bus.Op_i == OP_ST) || (bus.Op_i == OP_BEQ);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_FETCH;
      r_op    <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.MemReady_i) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_op <= bus.Op_i;
          if ((bus.Op_i == OP_R) || (bus.Op_i == OP_I))        r_state <= S_EXEC;
          else if ((bus.Op_i == OP_LD) || (bus.Op_i == OP_ST)) r_state <= S_MADDR;
          else if (bus.Op_i == OP_BEQ)                         r_state <= S_BRANCH;
          else                                                 r_state <= S_FETCH;
        end
        S_EXEC:  r_state <= S_WB;
        S_MADDR: r_state <= S_MEM;
        S_MEM: begin
          if (bus.MemReady_i) r_state <= w_is_st ? S_FETCH : S_WB;
        end
        S_WB:     r_state <= S_FETCH;
        S_BRANCH: r_state <= S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Outputs are gated by rst_i because FETCH (the reset state) would otherwise request a read.
  always_comb begin
    w_aluop    = ALU_ADD;
    w_alusrc   = 1'b0;
    w_regwrite = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_memtoreg = 1'b0;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_pcsrc    = 1'b0;
    w_illegal  = 1'b0;
    if (!rst_i) begin
      case (r_state)
        S_FETCH: begin
          w_memread = 1'b1;
          if (bus.MemReady_i) begin
            w_irwrite = 1'b1;
            w_pcwrite = 1'b1;
          end
        end
        S_DECODE: w_illegal = !w_dec_legal;
        S_EXEC: begin
          if (w_is_r) w_aluop  = ALU_FUNCT;
          else        w_alusrc = 1'b1;
        end
        S_MADDR: w_alusrc = 1'b1;
        S_MEM: begin
          if (w_is_st) w_memwrite = 1'b1;
          else         w_memread  = 1'b1;
        end
        S_WB: begin
          w_regwrite = 1'b1;
          w_memtoreg = w_is_ld;
        end
        S_BRANCH: begin
          w_aluop   = ALU_SUB;
          w_pcsrc   = 1'b1;
          w_pcwrite = bus.Zero_i;
        end
        default: ;
      endcase
    end
  end

  assign bus.ALUOp_o    = w_aluop;
  assign bus.ALUSrc_o   = w_alusrc;
  assign bus.RegWrite_o = w_regwrite;
  assign bus.MemRead_o  = w_memread;
  assign bus.MemWrite_o = w_memwrite;
  assign bus.MemtoReg_o = w_memtoreg;
  assign bus.IRWrite_o  = w_irwrite;
  assign bus.PCWrite_o  = w_pcwrite;
  assign bus.PCSrc_o    = w_pcsrc;
  assign bus.Illegal_o  = w_illegal;
  assign bus.State_o    = r_state;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_inst_ret;
  logic             w_retire;

  assign w_retire = (r_state == S_WB) || (r_state == S_BRANCH) ||
                    ((r_state == S_MEM) && bus.MemReady_i && w_is_st);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cycle_cnt <= '0;
      r_inst_ret  <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_retire) r_inst_ret <= r_inst_ret + CNT_W'(1);
    end
  end

  assign bus.CycleCnt_o = r_cycle_cnt;
  assign bus.InstRet_o  = r_inst_ret;
`else
  assign bus.CycleCnt_o = '0;
  assign bus.InstRet_o  = '0;
`endif

endmodule
